// File: rtl/ws2812b_rx.sv
// WS2812B single-wire receiver: decodes pulse-width-coded bits, captures the first
// 24 bits after each latch gap and forwards the remainder of the frame on dout.
module ws2812b_rx #(
   parameter int unsigned THRESH_CYCLES = 8,
   parameter int unsigned MIN_HIGH      = 2,
   parameter int unsigned MAX_HIGH      = 20,
   parameter int unsigned RESET_CYCLES  = 600
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        din,
   output logic        dout,
   output logic [23:0] data,
   output logic        valid,
   output logic        frame_end,
   output logic        err
);

   localparam int unsigned HW = $clog2(MAX_HIGH + 2);
   localparam int unsigned LW = $clog2(RESET_CYCLES + 1);
   localparam logic [HW-1:0] HIGH_SAT = HW'(MAX_HIGH + 1);
   localparam logic [HW-1:0] MIN_H    = HW'(MIN_HIGH);
   localparam logic [HW-1:0] MAX_H    = HW'(MAX_HIGH);
   localparam logic [HW-1:0] THRESH_H = HW'(THRESH_CYCLES);
   localparam logic [LW-1:0] LOW_SAT  = LW'(RESET_CYCLES);

   typedef enum logic [1:0] {
      WAIT_RESET = 2'd0,
      IDLE       = 2'd1,
      HIGH       = 2'd2,
      LOW        = 2'd3
   } state_t;

   state_t        state, state_nxt;
   logic          sync1, din_s, prev;
   logic          rise, fall;
   logic [HW-1:0] high_cnt, high_nxt;
   logic [LW-1:0] low_cnt, low_nxt;
   logic          gap_reach;
   logic          from_idle;
   logic          fwd_en;
   logic [4:0]    bit_cnt;
   logic [23:0]   shreg;
   logic          bit_ev, bit_val, err_ev, gap_ev;

   assign rise = din_s & ~prev;
   assign fall = ~din_s & prev;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      high_nxt = high_cnt;
      low_nxt  = low_cnt;
      if (rise)
         high_nxt = HW'(1);
      else if (din_s && high_cnt != HIGH_SAT)
         high_nxt = high_cnt + HW'(1);
      if (fall)
         low_nxt = LW'(1);
      else if (!din_s && low_cnt != LOW_SAT)
         low_nxt = low_cnt + LW'(1);
   end

   // A gap is recognised once, on the cycle low_cnt first hits saturation.
   assign gap_reach = (low_nxt == LOW_SAT) && (low_cnt != LOW_SAT);

   always_comb begin
      state_nxt = state;
      bit_ev    = 1'b0;
      bit_val   = 1'b0;
      err_ev    = 1'b0;
      gap_ev    = 1'b0;
      case (state)
         WAIT_RESET: begin
            if (gap_reach)
               state_nxt = IDLE;
         end
         IDLE, LOW: begin
            if (rise) begin
               state_nxt = HIGH;
            end else if (gap_reach) begin
               gap_ev    = 1'b1;
               state_nxt = IDLE;
            end
         end
         HIGH: begin
            if (fall) begin
               if (high_cnt < MIN_H) begin
                  state_nxt = from_idle ? IDLE : LOW;
               end else if (high_cnt > MAX_H) begin
                  err_ev    = 1'b1;
                  state_nxt = WAIT_RESET;
               end else begin
                  bit_ev    = 1'b1;
                  bit_val   = (high_cnt >= THRESH_H);
                  state_nxt = LOW;
               end
            end else if (high_cnt == HIGH_SAT) begin
               err_ev    = 1'b1;
               state_nxt = WAIT_RESET;
            end
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= WAIT_RESET;
         sync1     <= 1'b0;
         din_s     <= 1'b0;
         prev      <= 1'b0;
         high_cnt  <= '0;
         low_cnt   <= '0;
         from_idle <= 1'b0;
         fwd_en    <= 1'b0;
         bit_cnt   <= '0;
         shreg     <= '0;
         data      <= '0;
         dout      <= 1'b0;
         valid     <= 1'b0;
         frame_end <= 1'b0;
         err       <= 1'b0;
      end else begin
         sync1     <= din;
         din_s     <= sync1;
         prev      <= din_s;
         high_cnt  <= high_nxt;
         low_cnt   <= low_nxt;
         state     <= state_nxt;
         dout      <= fwd_en & din_s;
         valid     <= 1'b0;
         frame_end <= gap_ev;
         err       <= err_ev | (gap_ev && bit_cnt != 5'd0);
         if (rise)
            from_idle <= (state == IDLE);
         if (bit_ev && !fwd_en) begin
            shreg <= {bit_val, shreg[23:1]};
            if (bit_cnt == 5'd23) begin
               data    <= {bit_val, shreg[23:1]};
               valid   <= 1'b1;
               fwd_en  <= 1'b1;
               bit_cnt <= '0;
            end else begin
               bit_cnt <= bit_cnt + 5'd1;
            end
         end
         // Any gap or protocol error restarts word alignment for the next frame.
         if (gap_ev || err_ev) begin
            fwd_en  <= 1'b0;
            bit_cnt <= '0;
         end
      end
   end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Scoreboard bench for ws2812b_rx: expected words and forwarded pulse widths are queued
// at stimulus time and compared when the receiver emits valid / dout pulses.
module tb_ws2812b_rx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        din = 1'b0;
   logic        dout;
   logic [23:0] data;
   logic        valid, frame_end, err;

   ws2812b_rx dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .din       (din),
      .dout      (dout),
      .data      (data),
      .valid     (valid),
      .frame_end (frame_end),
      .err       (err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;
   logic [23:0] exp_q[$];
   int          width_q[$];
   int valid_cnt, fe_cnt, err_cnt, valid_cyc, fe_cyc, err_cyc;
   int dout_hi, dout_pulses, dout_rise_cyc, dout_w;
   int last_fall, start_cyc;
   logic dout_q = 1'b0;

   // Scoreboard side: pops expectations as the receiver produces results.
   always @(negedge clk) begin
      logic [23:0] e;
      int w;
      if (valid) begin
         valid_cnt++;
         valid_cyc = cyc;
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_valid: unexpected valid, data=%h, nothing expected", data);
         end else begin
            e = exp_q.pop_front();
            if (data !== e) begin
               n_bad++;
               $display("FAIL sb_data: got %h expected %h", data, e);
            end
         end
      end
      if (frame_end) begin fe_cnt++;  fe_cyc  = cyc; end
      if (err)       begin err_cnt++; err_cyc = cyc; end
      if (dout) begin
         dout_hi++;
         if (!dout_q) begin
            dout_pulses++;
            if (dout_pulses == 1) dout_rise_cyc = cyc;
            dout_w = 0;
         end
         dout_w++;
      end else if (dout_q) begin
         n_cmp++;
         if (width_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_dout: unexpected dout pulse width %0d, none expected", dout_w);
         end else begin
            w = width_q.pop_front();
            if (dout_w !== w) begin
               n_bad++;
               $display("FAIL sb_dout_width: got %0d expected %0d", dout_w, w);
            end
         end
      end
      dout_q = dout;
   end

   task automatic clear_stats();
      valid_cnt = 0; fe_cnt = 0; err_cnt = 0;
      valid_cyc = -1; fe_cyc = -1; err_cyc = -2;
      dout_hi = 0; dout_pulses = 0; dout_rise_cyc = -1;
   endtask

   task automatic drive(input logic v, input int n);
      din = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_pulse(input int h, input int l);
      drive(1'b1, h);
      last_fall = cyc;
      drive(1'b0, l);
   endtask

   task automatic send_bit(input logic b);
      if (b) send_pulse(10, 5);
      else   send_pulse(5, 10);
   endtask

   task automatic send_word(input logic [23:0] w);
      for (int i = 0; i < 24; i++) send_bit(w[i]);
   endtask

   task automatic expect_int(input string name, input int got, input int want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      din   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({dout, valid, frame_end, err, data} !== 28'd0) begin
         n_bad++;
         $display("FAIL reset_outputs: got %h expected 0", {dout, valid, frame_end, err, data});
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(1'b0, 620);
   endtask

   task automatic test_basic();
      clear_stats();
      exp_q.push_back(24'hA5C30F);
      send_word(24'hA5C30F);
      drive(1'b0, 620);
      n_cmp++;
      if (data !== 24'hA5C30F) begin
         n_bad++;
         $display("FAIL basic_data: got %h expected a5c30f", data);
      end
      expect_int("basic_valid_cnt", valid_cnt, 1);
      expect_int("basic_valid_delay", valid_cyc - last_fall, 3);
      expect_int("basic_dout_quiet", dout_hi, 0);
      expect_int("basic_frame_end_cnt", fe_cnt, 1);
      n_cmp++;
      if (fe_cyc - last_fall < 601 || fe_cyc - last_fall > 602) begin
         n_bad++;
         $display("FAIL basic_frame_end_time: got %0d expected 601..602", fe_cyc - last_fall);
      end
      expect_int("basic_err_cnt", err_cnt, 0);
   endtask

   task automatic test_forward();
      logic [23:0] w2;
      w2 = 24'hABCDEF;
      clear_stats();
      exp_q.push_back(24'h123456);
      send_word(24'h123456);
      for (int i = 0; i < 24; i++) width_q.push_back(w2[i] ? 10 : 5);
      start_cyc = cyc;
      send_word(w2);
      drive(1'b0, 620);
      expect_int("fwd_valid_cnt", valid_cnt, 1);
      n_cmp++;
      if (data !== 24'h123456) begin
         n_bad++;
         $display("FAIL fwd_data: got %h expected 123456", data);
      end
      expect_int("fwd_dout_pulses", dout_pulses, 24);
      expect_int("fwd_dout_delay", dout_rise_cyc - start_cyc, 3);
      expect_int("fwd_width_left", width_q.size(), 0);
      expect_int("fwd_frame_end_cnt", fe_cnt, 1);
      expect_int("fwd_dout_after_gap", int'(dout), 0);
   endtask

   task automatic test_no_initial_gap();
      clear_stats();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_word(24'h111111);
      drive(1'b0, 620);
      expect_int("nogap_valid_cnt", valid_cnt, 0);
      expect_int("nogap_err_cnt", err_cnt, 0);
      exp_q.push_back(24'h654321);
      send_word(24'h654321);
      drive(1'b0, 620);
      expect_int("nogap_capture_cnt", valid_cnt, 1);
      n_cmp++;
      if (data !== 24'h654321) begin
         n_bad++;
         $display("FAIL nogap_data: got %h expected 654321", data);
      end
   endtask

   task automatic test_partial();
      logic [23:0] w;
      w = 24'h0003A7;
      clear_stats();
      for (int i = 0; i < 10; i++) send_bit(w[i]);
      drive(1'b0, 620);
      expect_int("partial_err_cnt", err_cnt, 1);
      expect_int("partial_frame_end_cnt", fe_cnt, 1);
      expect_int("partial_err_with_fe", err_cyc, fe_cyc);
      expect_int("partial_valid_cnt", valid_cnt, 0);
      n_cmp++;
      if (data !== 24'h654321) begin
         n_bad++;
         $display("FAIL partial_data_held: got %h expected 654321", data);
      end
   endtask

   task automatic test_widths();
      logic [23:0] w;
      w = 24'h7E3C0A;
      clear_stats();
      exp_q.push_back(w);
      send_pulse(7, 10);
      send_pulse(8, 10);
      send_pulse(1, 6);
      send_pulse(2, 10);
      send_pulse(20, 5);
      for (int i = 4; i < 24; i++) send_bit(w[i]);
      drive(1'b0, 620);
      expect_int("widths_valid_cnt", valid_cnt, 1);
      expect_int("widths_err_cnt", err_cnt, 0);
      n_cmp++;
      if (data !== w) begin
         n_bad++;
         $display("FAIL widths_data: got %h expected %h", data, w);
      end
   endtask

   task automatic test_long_pulse();
      logic [23:0] y;
      y = 24'h3C96E1;
      clear_stats();
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      send_pulse(30, 10);
      send_word(24'hFFFFFF);
      drive(1'b0, 620);
      expect_int("long_err_cnt", err_cnt, 1);
      expect_int("long_valid_cnt", valid_cnt, 0);
      expect_int("long_frame_end_cnt", fe_cnt, 0);
      exp_q.push_back(y);
      send_word(y);
      drive(1'b0, 620);
      expect_int("long_recover_valid", valid_cnt, 1);
      n_cmp++;
      if (data !== y) begin
         n_bad++;
         $display("FAIL long_recover_data: got %h expected %h", data, y);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [23:0] z, w2;
      z  = 24'h5AA5F0;
      w2 = 24'h0F1E2D;
      clear_stats();
      for (int i = 0; i < 12; i++) send_bit(z[i]);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({dout, valid, frame_end, err, data} !== 28'd0) begin
         n_bad++;
         $display("FAIL midreset_outputs: got %h expected 0", {dout, valid, frame_end, err, data});
      end
      @(posedge clk);
      #1;
      for (int i = 12; i < 24; i++) send_bit(z[i]);
      drive(1'b0, 100);
      expect_int("midreset_valid_cnt", valid_cnt, 0);
      drive(1'b0, 620);
      exp_q.push_back(w2);
      send_word(w2);
      drive(1'b0, 620);
      expect_int("midreset_capture_cnt", valid_cnt, 1);
      expect_int("midreset_frame_end_cnt", fe_cnt, 1);
      n_cmp++;
      if (data !== w2) begin
         n_bad++;
         $display("FAIL midreset_data: got %h expected %h", data, w2);
      end
   endtask

   initial begin
      clear_stats();
      test_reset();
      test_basic();
      test_forward();
      test_no_initial_gap();
      test_partial();
      test_widths();
      test_long_pulse();
      test_reset_mid_frame();
      expect_int("sb_words_left", exp_q.size(), 0);
      expect_int("sb_widths_left", width_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
